// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: scan-test initiator for a single scan chain.
// Each accepted START runs one full pattern. The pattern is shifted in
// serially with SE=1, then one functional capture cycle runs with SE=0,
// then the response is shifted out serially into a parallel register.
// The chain shares this block's clock. Cell 0 is fed by SI, and the last
// cell drives SO.
// Optional compare feature: define SCAN_CTRL_CMP_EN to add the EXP/MASK
// inputs and the MISMATCH output.

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 clk_i,
    input  logic                 rn_i,
    input  logic                 start_i,
    input  logic [CHAIN_LEN-1:0] pat_in_i,
    input  logic                 so_i,
`ifdef SCAN_CTRL_CMP_EN
    input  logic [CHAIN_LEN-1:0] exp_in_i,
    input  logic [CHAIN_LEN-1:0] mask_in_i,
    output logic                 mismatch_o,
`endif
    output logic                 se_o,
    output logic                 si_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CHAIN_LEN-1:0] resp_out_o
);

    // The counter only has to count up to CHAIN_LEN-1. Its width is derived
    // from the chain length and is kept local so that it cannot be overridden.
    localparam int              CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        FIN
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // The MSB of the pattern goes straight to SI on the accepting edge.
    // Only the remaining CHAIN_LEN-1 bits are stored here, MSB first.
    logic [CHAIN_LEN-2:0]   shreg_q;
    logic [CHAIN_LEN-2:0]   shreg_d;

    // The response shifter holds the first CHAIN_LEN-1 SO samples. The final
    // sample is joined in on the last UNLOAD edge, straight into resp_q.
    logic [CHAIN_LEN-2:0]   resp_sh_q;
    logic [CHAIN_LEN-1:0]   resp_shift_d;

    logic                   se_q;
    logic                   si_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CHAIN_LEN-1:0]   resp_q;

`ifdef SCAN_CTRL_CMP_EN
    logic [CHAIN_LEN-1:0]   exp_q;
    logic [CHAIN_LEN-1:0]   mask_q;
    logic                   mismatch_q;
    logic                   mismatch_d;
`endif

    // Datapath next values: counter increment, pattern shift, and response
    // shift. The first SO sample ends up in the MSB.
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        shreg_d      = shreg_q << 1;
        resp_shift_d = {resp_sh_q, so_i};
    end

`ifdef SCAN_CTRL_CMP_EN
    // Compare the completed response against the expected value. Mask bits
    // set to 1 mark don't-care positions.
    always_comb begin
        mismatch_d = |((resp_shift_d ^ exp_q) & ~mask_q);
    end
`endif

    // Sequencer: IDLE -> SHIFT -> CAPTURE -> UNLOAD -> FIN -> IDLE.
    // All scan-interface outputs are registered.
    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            resp_sh_q <= '0;
            se_q      <= 1'b0;
            si_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
`ifdef SCAN_CTRL_CMP_EN
            exp_q      <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    se_q <= 1'b0;
                    si_q <= 1'b0;
                    if (start_i) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shreg_q <= pat_in_i[CHAIN_LEN-2:0];
                        se_q    <= 1'b1;
                        si_q    <= pat_in_i[CHAIN_LEN-1];
                        busy_q  <= 1'b1;
`ifdef SCAN_CTRL_CMP_EN
                        exp_q   <= exp_in_i;
                        mask_q  <= mask_in_i;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        state_q <= CAPTURE;
                        se_q    <= 1'b0;
                        si_q    <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_d;
                        si_q    <= shreg_q[CHAIN_LEN-2];
                        shreg_q <= shreg_d;
                    end
                end
                CAPTURE: begin
                    state_q <= UNLOAD;
                    cnt_q   <= '0;
                    se_q    <= 1'b1;
                    si_q    <= 1'b0;
                end
                UNLOAD: begin
                    resp_sh_q <= resp_shift_d[CHAIN_LEN-2:0];
                    if (cnt_q == LAST) begin
                        state_q <= FIN;
                        se_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        resp_q  <= resp_shift_d;
`ifdef SCAN_CTRL_CMP_EN
                        mismatch_q <= mismatch_d;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    se_q    <= 1'b0;
                    si_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    se_q    <= 1'b0;
                    si_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign se_o       = se_q;
    assign si_o       = si_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign resp_out_o = resp_q;
`ifdef SCAN_CTRL_CMP_EN
    assign mismatch_o = mismatch_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl with CHAIN_LEN=8.
// A behavioural 8-cell scan chain is attached to the DUT. During capture,
// each cell either holds its value or inverts it.
// Compare checks are enabled with SCAN_CTRL_CMP_EN.

module tb_scan_chain_ctrl;

    logic       clk;
    logic       rn;
    logic       startSig;
    logic [7:0] patIn;
    logic       so;
    logic       se;
    logic       si;
    logic       busy;
    logic       done;
    logic [7:0] respOut;
`ifdef SCAN_CTRL_CMP_EN
    logic [7:0] expIn;
    logic [7:0] maskIn;
    logic       mismatch;
`endif

    logic [7:0] chainQ = '0;
    logic       invertChain = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
        .clk_i      (clk),
        .rn_i       (rn),
        .start_i    (startSig),
        .pat_in_i   (patIn),
        .so_i       (so),
`ifdef SCAN_CTRL_CMP_EN
        .exp_in_i   (expIn),
        .mask_in_i  (maskIn),
        .mismatch_o (mismatch),
`endif
        .se_o       (se),
        .si_o       (si),
        .busy_o     (busy),
        .done_o     (done),
        .resp_out_o (respOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scan chain model: shift from SI toward SO when SE=1, otherwise perform
    // a functional capture (identity or inverting).
    always @(posedge clk) begin
        if (se)
            chainQ <= {chainQ[6:0], si};
        else if (invertChain)
            chainQ <= ~chainQ;
    end
    assign so = chainQ[7];

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Run one full sequence from IDLE and check the SI stream, SE gap,
    // BUSY length, DONE timing, and response. pulseStart pokes START
    // during UNLOAD and during FIN.
    task automatic applyStimulus(input string name, input logic [7:0] pat,
                                 input logic [7:0] expResp, input logic [7:0] prevResp,
                                 input logic [7:0] expVal, input logic [7:0] maskVal,
                                 input logic expMis, input bit pulseStart);
        logic [7:0] siSeq;
        logic       seCapture;
        logic [7:0] respMid;
        logic [7:0] respDone;
        logic       misDone;
        int         busyCnt;
        int         seLowCnt;
        int         doneCnt;
        int         doneCyc;
        siSeq = '0; seCapture = 1'b1; respMid = '0; respDone = '0; misDone = 1'b0;
        busyCnt = 0; seLowCnt = 0; doneCnt = 0; doneCyc = 0;
        startSig = 1'b1;
        patIn    = pat;
`ifdef SCAN_CTRL_CMP_EN
        expIn    = expVal;
        maskIn   = maskVal;
`endif
        @(negedge clk);
        startSig = 1'b0;
        patIn    = ~pat;
`ifdef SCAN_CTRL_CMP_EN
        expIn    = ~expVal;
        maskIn   = ~maskVal;
`endif
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy) busyCnt++;
            if (cyc <= 8) siSeq = {siSeq[6:0], si};
            if (cyc == 9) seCapture = se;
            if (cyc <= 17 && !se) seLowCnt++;
            if (cyc == 10) respMid = respOut;
            if (done) begin
                doneCnt++;
                if (doneCyc == 0) begin
                    doneCyc  = cyc;
                    respDone = respOut;
`ifdef SCAN_CTRL_CMP_EN
                    misDone  = mismatch;
`endif
                end
            end
            startSig = pulseStart && (cyc == 12 || cyc == 18);
            @(negedge clk);
        end
        startSig = 1'b0;
        checkOutput({name, "_si_seq"}, 32'(siSeq), 32'(pat));
        checkOutput({name, "_se_capture"}, 32'(seCapture), 32'd0);
        checkOutput({name, "_se_low_cycles"}, 32'(seLowCnt), 32'd1);
        checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'd17);
        checkOutput({name, "_done_cycle"}, 32'(doneCyc), 32'd18);
        checkOutput({name, "_done_count"}, 32'(doneCnt), 32'd1);
        checkOutput({name, "_resp_held"}, 32'(respMid), 32'(prevResp));
        checkOutput({name, "_resp"}, 32'(respDone), 32'(expResp));
        checkOutput({name, "_resp_after"}, 32'(respOut), 32'(expResp));
`ifdef SCAN_CTRL_CMP_EN
        checkOutput({name, "_mismatch"}, 32'(misDone), 32'(expMis));
        checkOutput({name, "_mismatch_held"}, 32'(mismatch), 32'(expMis));
`else
        if (expMis !== misDone) begin end
`endif
    endtask

    initial begin
        int doneCnt;
        int done1;
        int done2;
        logic [7:0] resp1;
        logic [7:0] resp2;
        logic       busySeen;
        rn = 1'b0; startSig = 1'b0; patIn = '0;
`ifdef SCAN_CTRL_CMP_EN
        expIn = '0; maskIn = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_se", 32'(se), 32'd0);
        checkOutput("reset_si", 32'(si), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_resp", 32'(respOut), 32'd0);
        rn = 1'b1;
        @(negedge clk);

        $display("[TB] identity chain, pattern A5");
        invertChain = 1'b0;
        applyStimulus("ident_a5", 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);

        $display("[TB] inverting chain, pattern 3C, START poked in UNLOAD and FIN");
        invertChain = 1'b1;
        applyStimulus("invert_3c", 8'h3C, 8'hC3, 8'hA5, 8'h3C, 8'h00, 1'b1, 1'b1);

        $display("[TB] START held high, patterns 01 then 80");
        invertChain = 1'b0;
        doneCnt = 0; done1 = 0; done2 = 0; resp1 = '0; resp2 = '0;
        startSig = 1'b1;
        patIn    = 8'h01;
        @(negedge clk);
        patIn = 8'h80;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) begin done1 = cyc; resp1 = respOut; end
                if (doneCnt == 2) begin done2 = cyc; resp2 = respOut; end
            end
            if (cyc == 20) startSig = 1'b0;
            @(negedge clk);
        end
        startSig = 1'b0;
        checkOutput("b2b_done_count", 32'(doneCnt), 32'd2);
        checkOutput("b2b_first_done", 32'(done1), 32'd18);
        checkOutput("b2b_spacing", 32'(done2 - done1), 32'd19);
        checkOutput("b2b_resp1", 32'(resp1), 32'h01);
        checkOutput("b2b_resp2", 32'(resp2), 32'h80);

        $display("[TB] reset in the middle of SHIFT");
        startSig = 1'b1;
        patIn    = 8'hA5;
        @(negedge clk);
        startSig = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rn = 1'b0;
        @(negedge clk);
        checkOutput("midreset_se", 32'(se), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_resp", 32'(respOut), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rn = 1'b1;
        doneCnt = 0; busySeen = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (done) doneCnt++;
            if (busy) busySeen = 1'b1;
            @(negedge clk);
        end
        checkOutput("midreset_no_done", 32'(doneCnt), 32'd0);
        checkOutput("midreset_no_busy", 32'(busySeen), 32'd0);
        applyStimulus("restart_a5", 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);

`ifdef SCAN_CTRL_CMP_EN
        $display("[TB] compare: unmasked and masked mismatch");
        applyStimulus("cmp_nomask", 8'hFF, 8'hFF, 8'hA5, 8'hFE, 8'h00, 1'b1, 1'b0);
        applyStimulus("cmp_mask", 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
